alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
Bit-serial 16-bit ALU sequencer for the CPU datapath. It is the initiator that drives a 1-bit ALU slice. It accepts a full-width operation and feeds the operand bits LSB-first into the slice. Each cycle it registers the slice CarryOut back into CIN and shifts Result bits into a result register. It trades latency (WIDTH cycles) for area against the parallel ripple ALU and reports completion with a start/busy/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits (>=2)
CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only in IDLE
op  input  3  000 AND, 001 OR, 010 XOR, 011 ADD, 111 SUB; others illegal
a  input  WIDTH  operand A, sampled on accepted start
b  input  WIDTH  operand B, sampled on accepted start
busy  output  1  high from the cycle after acceptance through the last SHIFT cycle
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  result, held until next accepted start
carry  output  1  final CarryOut (ADD/SUB); 0 for logic ops
illegal  output  1  set with done when op was illegal

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state=IDLE; busy=0, done=0, result=0, carry=0, illegal=0; shift regs, counter, carry FF cleared. Reset asserted mid-operation aborts immediately. No done is produced for the aborted operation.
- States: IDLE, SHIFT, DONE.
- IDLE: on start=1, latch a, b and op; cnt=0. Carry FF = 1 for SUB, else 0. BInvert = (op==111). Go to SHIFT.
- SHIFT: the slice sees A=a_sh[0], B=b_sh[0], CIN=carry FF and BInvert. Slice op is {0, op[1:0]}; SUB uses slice code 011 with BInvert=1.
- Each SHIFT cycle: res_sh <= {slice Result, res_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; carry FF <= CarryOut; cnt++.
- When cnt==WIDTH-1, go to DONE. SHIFT therefore lasts exactly WIDTH cycles.
- DONE (1 cycle): done=1, result=res_sh. carry = carry FF if op is ADD/SUB, else 0. Then go to IDLE.
- Latency: start sampled at edge N → done high during cycle N+WIDTH+1.
- start while busy or in DONE is ignored, not queued. start in the cycle after done is accepted normally.
- Illegal op: runs as AND, result = a & b, illegal=1 with done.
- SUB: result = a - b mod 2**WIDTH; carry=1 means no borrow (a>=b unsigned).
- Operands change while busy: no effect.

Optional Feature:
Macro ALU_SERIAL_FLAGS_EN.
- Defined: adds outputs zero (1), neg (1) and ovf (1), valid with done and held with result.
  - zero = (result==0).
  - neg = result[WIDTH-1].
  - ovf = signed overflow for ADD/SUB, computed as CIN xor CarryOut of the MSB slice cycle and captured during the last SHIFT cycle; 0 for logic ops.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings (OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB);
  - the slice-op width constant;
  - the state enum {IDLE, SHIFT, DONE}.
- One sub-module: alu_bit_slice, the combinational 1-bit slice (B invert mux, AND/OR/XOR, full adder, 4:1 result mux) with ports A, B, CIN, BInvert, Op, Result, CarryOut.
- The sequencer instantiates it once.

Test Plan:
- ADD: a=16'h00FF, b=16'h0001, op=011 → done at start+17 cycles, result=16'h0100, carry=0; busy high for exactly 16 cycles.
- SUB borrow: a=16'h0003, b=16'h0005, op=111 → result=16'hFFFE, carry=0. With a=16'h0005, b=16'h0003 → result=16'h0002, carry=1.
- Logic plus illegal op: a=16'hF0F0, b=16'hFF00 with op 000/001/010 → 16'hF000 / 16'hFFF0 / 16'h0FF0, carry=0. op=100 → 16'hF000, illegal=1.
- Handshake: start held high continuously → ops accepted only in IDLE, one done per 18 cycles. start pulse mid-SHIFT with different operands → ignored, first result unchanged.
- Reset mid-op: assert rst_n=0 during cycle 8 of SHIFT → all outputs 0 asynchronously, no done. A new start after release completes correctly.
- ALU_SERIAL_FLAGS_EN: ADD a=16'h7FFF, b=16'h0001 → result=16'h8000, ovf=1, neg=1, zero=0. SUB a=b=16'h1234 → zero=1, carry=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: operation codes, slice-op width, sequencer states.
// Pure declarations, no logic.
package alu_pkg;

    localparam int SLICE_OP_W = 3;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) ||
               (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic op_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// 1-bit ALU slice: B-invert mux, AND/OR/XOR, full adder, 4:1 result mux.
// Latency: purely combinational.
// Backpressure: none; the sequencer owns all timing.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic                  A,
    input  logic                  B,
    input  logic                  CIN,
    input  logic                  BInvert,
    input  logic [SLICE_OP_W-1:0] Op,
    output logic                  Result,
    output logic                  CarryOut
);

    logic b_eff;
    logic sum;
    // The sequencer always drives Op[2] low; the bit is kept for slice-code compatibility.
    logic unused_op_msb;

    assign unused_op_msb = Op[SLICE_OP_W-1];
    assign b_eff         = B ^ BInvert;
    assign sum           = A ^ b_eff ^ CIN;
    assign CarryOut      = (A & b_eff) | (CIN & (A ^ b_eff));

    always_comb begin
        Result = 1'b0;
        case (Op[1:0])
            2'b00:   Result = A & b_eff;
            2'b01:   Result = A | b_eff;
            2'b10:   Result = A ^ b_eff;
            default: Result = sum;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial WIDTH-bit ALU sequencer driving one alu_bit_slice LSB-first; flags via ALU_SERIAL_FLAGS_EN.
// Latency: start accepted at edge N, done high for one cycle after edge N+WIDTH.
// Backpressure: start is honoured only in IDLE; requests while busy or done are dropped.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             illegal
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_final;
    logic [CNT_W-1:0] cnt;
    logic             cy;
    logic [1:0]       op_q;
    logic             binv_q;
    logic             arith_q;
    logic             illegal_q;

    logic             s_res;
    logic             s_co;

    alu_bit_slice u_slice (
        .A        (a_sh[0]),
        .B        (b_sh[0]),
        .CIN      (cy),
        .BInvert  (binv_q),
        .Op       ({1'b0, op_q}),
        .Result   (s_res),
        .CarryOut (s_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST_CNT) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign res_final = {s_res, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            cnt       <= '0;
            cy        <= 1'b0;
            op_q      <= 2'b00;
            binv_q    <= 1'b0;
            arith_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            a_sh      <= a;
            b_sh      <= b;
            cnt       <= '0;
            cy        <= (op == OP_SUB);
            binv_q    <= (op == OP_SUB);
            // Illegal codes run through the slice as AND.
            op_q      <= op_legal(op) ? op[1:0] : 2'b00;
            arith_q   <= op_arith(op);
            illegal_q <= !op_legal(op);
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_final;
            cy     <= s_co;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Outputs are captured on the last SHIFT edge so they are valid together with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            carry   <= 1'b0;
            illegal <= 1'b0;
        end else if (last) begin
            result  <= res_final;
            carry   <= arith_q & s_co;
            illegal <= illegal_q;
        end
    end

`ifdef ALU_SERIAL_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
            neg  <= 1'b0;
            ovf  <= 1'b0;
        end else if (last) begin
            zero <= (res_final == '0);
            neg  <= s_res;
            ovf  <= arith_q & (cy ^ s_co);
        end
    end
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Randomised and directed bench for alu_serial_seq against an arithmetic reference model.
module tb_alu_serial_seq;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       op = 3'b000;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             illegal;
`ifdef ALU_SERIAL_FLAGS_EN
    logic             zero;
    logic             neg;
    logic             ovf;
`endif

    int compared = 0;
    int mismatched = 0;

    alu_serial_seq #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry),
        .illegal (illegal)
`ifdef ALU_SERIAL_FLAGS_EN
        ,
        .zero    (zero),
        .neg     (neg),
        .ovf     (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain WIDTH-bit arithmetic on whole operands.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic [2:0] mop,
                         output logic [WIDTH-1:0] r, output logic c, output logic il, output logic v);
        logic [WIDTH:0] s;
        r = '0; c = 1'b0; il = 1'b0; v = 1'b0;
        case (mop)
            3'b000: r = ma & mb;
            3'b001: r = ma | mb;
            3'b010: r = ma ^ mb;
            3'b011: begin
                s = {1'b0, ma} + {1'b0, mb};
                r = s[WIDTH-1:0];
                c = s[WIDTH];
                v = (ma[WIDTH-1] == mb[WIDTH-1]) && (r[WIDTH-1] != ma[WIDTH-1]);
            end
            3'b111: begin
                r = ma - mb;
                c = (ma >= mb);
                v = (ma[WIDTH-1] != mb[WIDTH-1]) && (r[WIDTH-1] != ma[WIDTH-1]);
            end
            default: begin
                r  = ma & mb;
                il = 1'b1;
            end
        endcase
    endtask

    // Edges until done is seen (bounded); operands are scrambled meanwhile to prove they are ignored.
    task automatic wait_done(output int n, output int bsy);
        n = 0;
        bsy = 0;
        do begin
            if (busy) bsy++;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            tick;
            n++;
        end while (!done && n < 60);
    endtask

    task automatic check_outputs(input string tag, input logic [WIDTH-1:0] er, input logic ec,
                                 input logic ei, input logic ev);
        check({tag, ".result"}, 32'(result), 32'(er));
        check({tag, ".carry"}, 32'(carry), 32'(ec));
        check({tag, ".illegal"}, 32'(illegal), 32'(ei));
`ifdef ALU_SERIAL_FLAGS_EN
        check({tag, ".zero"}, 32'(zero), 32'(er == '0));
        check({tag, ".neg"}, 32'(neg), 32'(er[WIDTH-1]));
        check({tag, ".ovf"}, 32'(ovf), 32'(ev));
`else
        if (ev === 1'bx) check({tag, ".ovf_x"}, 32'(ev), 32'(0));
`endif
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_b,
                          input logic [2:0] top);
        logic [WIDTH-1:0] er;
        logic ec, ei, ev;
        int n, bsy;
        model(ta, tb_b, top, er, ec, ei, ev);
        a = ta;
        b = tb_b;
        op = top;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(n, bsy);
        check({tag, ".done"}, 32'(done), 32'(1));
        check({tag, ".latency"}, 32'(n + 1), 32'(WIDTH + 1));
        check({tag, ".busy_cycles"}, 32'(bsy), 32'(WIDTH));
        check_outputs(tag, er, ec, ei, ev);
        tick;
        check({tag, ".done_pulse"}, 32'(done), 32'(0));
    endtask

    initial begin
        logic [WIDTH-1:0] er, ta, tbv;
        logic ec, ei, ev;
        logic [2:0] top;
        int n, bsy, seen;

        // Reset state
        repeat (3) tick;
        check("rst.busy", 32'(busy), 32'(0));
        check("rst.done", 32'(done), 32'(0));
        check("rst.result", 32'(result), 32'(0));
        check("rst.carry", 32'(carry), 32'(0));
        check("rst.illegal", 32'(illegal), 32'(0));
        rst_n = 1'b1;
        tick;

        // Directed cases
        run_op("add_ff_1", 16'h00FF, 16'h0001, 3'b011);
        run_op("sub_borrow", 16'h0003, 16'h0005, 3'b111);
        run_op("sub_noborrow", 16'h0005, 16'h0003, 3'b111);
        run_op("and", 16'hF0F0, 16'hFF00, 3'b000);
        run_op("or", 16'hF0F0, 16'hFF00, 3'b001);
        run_op("xor", 16'hF0F0, 16'hFF00, 3'b010);
        run_op("illegal100", 16'hF0F0, 16'hFF00, 3'b100);
        run_op("illegal110", 16'h1234, 16'h0F0F, 3'b110);
        run_op("add_ovf", 16'h7FFF, 16'h0001, 3'b011);
        run_op("sub_equal", 16'h1234, 16'h1234, 3'b111);
        run_op("add_wrap", 16'hFFFF, 16'h0001, 3'b011);

        // Random operations, all eight op codes
        for (int i = 0; i < 40; i++) begin
            run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)));
        end

        // start held high: one done every WIDTH+2 edges
        ta = 16'h1000; tbv = 16'h0234; top = 3'b011;
        model(ta, tbv, top, er, ec, ei, ev);
        op = top;
        a = ta;
        b = tbv;
        start = 1'b1;
        tick;
        wait_done(n, bsy);
        check("hold.first_latency", 32'(n + 1), 32'(WIDTH + 1));
        check("hold.first_result", 32'(result), 32'(er));
        a = ta;
        b = tbv;
        // Operands must be stable at the re-accept edge; scrambling in wait_done would change them.
        tick;
        check("hold.done_gone", 32'(done), 32'(0));
        a = ta;
        b = tbv;
        tick;
        check("hold.reaccepted", 32'(busy), 32'(1));
        wait_done(n, bsy);
        check("hold.period", 32'(n + 2), 32'(WIDTH + 2));
        check("hold.second_result", 32'(result), 32'(er));
        start = 1'b0;
        tick;
        tick;
        check("hold.no_extra", 32'(busy), 32'(0));

        // start pulse mid-SHIFT is ignored
        model(16'h0003, 16'h0005, 3'b111, er, ec, ei, ev);
        a = 16'h0003; b = 16'h0005; op = 3'b111;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        a = 16'hFFFF; b = 16'h0001; op = 3'b011;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(n, bsy);
        check("mid.latency", 32'(n + 7), 32'(WIDTH + 1));
        check_outputs("mid", er, ec, ei, ev);
        tick;
        tick;
        check("mid.not_queued", 32'(busy), 32'(0));

        // Reset in SHIFT cycle 8 aborts immediately with no done
        run_op("pre_rst", 16'h1234, 16'h1111, 3'b011);
        a = 16'hAAAA; b = 16'h5555; op = 3'b011;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (7) tick;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.busy", 32'(busy), 32'(0));
        check("arst.done", 32'(done), 32'(0));
        check("arst.result", 32'(result), 32'(0));
        check("arst.carry", 32'(carry), 32'(0));
        check("arst.illegal", 32'(illegal), 32'(0));
        tick;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick;
            if (done || busy) seen++;
        end
        check("arst.no_done", 32'(seen), 32'(0));
        run_op("post_rst", 16'h8001, 16'h7FFF, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
